// File: rtl/fsb_mem_node_pkg.sv
// fsb_mem_node_pkg: opcodes, packet layout and FSM states shared by the FSB memory node.
package fsb_mem_node_pkg;
   localparam logic [7:0] op_write  = 8'h01;
   localparam logic [7:0] op_read   = 8'h02;
   localparam logic [7:0] op_status = 8'h03;
   localparam logic [7:0] op_wack   = 8'h81;
   localparam logic [7:0] op_rdata  = 8'h82;
   localparam logic [7:0] op_stat   = 8'h83;
   typedef struct packed {
      logic [7:0]  opcode;
      logic [7:0]  tag;
      logic [31:0] addr;
      logic [31:0] data;
   } fsb_mem_pkt_s;
   typedef enum logic [1:0] {IDLE, READ_WAIT, RESP} state_e;
endpackage

// File: rtl/fsb_mem_node_array.sv
// fsb_mem_node_array: single-port synchronous scratch memory with one-cycle read latency.
module fsb_mem_node_array #(
   parameter int els_p        = 256,
   parameter int data_width_p = 32,
   parameter int addr_width_p = $clog2(els_p)
) (
   input  logic                    clk_i,
   input  logic                    w_i,
   input  logic                    r_i,
   input  logic [addr_width_p-1:0] addr_i,
   input  logic [data_width_p-1:0] data_i,
   output logic [data_width_p-1:0] data_o
);
   logic [data_width_p-1:0] mem [els_p];
   always_ff @(posedge clk_i) begin
      if (w_i) mem[addr_i] <= data_i;
      if (r_i) data_o <= mem[addr_i];
   end
endmodule

// File: rtl/fsb_mem_node.sv
// fsb_mem_node: FSB client executing WRITE/READ/STATUS requests against scratch memory and counters.
// Define FSB_MEM_NODE_WRITE_ACK_EN to make every WRITE return a WACK response.
module fsb_mem_node
   import fsb_mem_node_pkg::*;
#(
   parameter int fsb_width_p  = 80,
   parameter int els_p        = 256,
   parameter int data_width_p = 32
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   fsb_v_i,
   input  logic [fsb_width_p-1:0] fsb_data_i,
   output logic                   fsb_ready_o,
   output logic                   fsb_v_o,
   output logic [fsb_width_p-1:0] fsb_data_o,
   input  logic                   fsb_ready_i
);
   localparam int lg_els_lp = $clog2(els_p);
   fsb_mem_pkt_s req, resp_r, resp_n;
   state_e state_r, state_n;
   logic [15:0] wr_count_r, err_count_r;
   logic [data_width_p-1:0] mem_data;
   logic accept, is_write, is_read, is_stat, is_bad;
   assign req         = fsb_data_i;
   assign fsb_ready_o = (state_r == IDLE) & ~reset_i;
   assign accept      = fsb_v_i & fsb_ready_o;
   assign is_write    = accept & (req.opcode == op_write);
   assign is_read     = accept & (req.opcode == op_read);
   assign is_stat     = accept & (req.opcode == op_status);
   assign is_bad      = accept & ~(req.opcode inside {op_write, op_read, op_status});
   assign fsb_v_o     = state_r == RESP;
   assign fsb_data_o  = resp_r;
   fsb_mem_node_array #(.els_p(els_p), .data_width_p(data_width_p), .addr_width_p(lg_els_lp)) array (
      .clk_i (clk_i),
      .w_i   (is_write),
      .r_i   (is_read),
      .addr_i(req.addr[lg_els_lp-1:0]),
      .data_i(req.data),
      .data_o(mem_data)
   );
   always_comb begin
      state_n = state_r;
      resp_n  = resp_r;
      case (state_r)
         IDLE: begin
            if (is_read) begin
               resp_n  = '{op_rdata, req.tag, req.addr, 32'h0};
               state_n = READ_WAIT;
            end else if (is_stat) begin
               resp_n  = '{op_stat, req.tag, req.addr, {err_count_r, wr_count_r}};
               state_n = RESP;
            end
`ifdef FSB_MEM_NODE_WRITE_ACK_EN
            else if (is_write) begin
               resp_n  = '{op_wack, req.tag, req.addr, req.data};
               state_n = RESP;
            end
`endif
         end
         READ_WAIT: begin
            resp_n.data = mem_data;
            state_n     = RESP;
         end
         RESP: state_n = fsb_ready_i ? IDLE : RESP;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r     <= IDLE;
         resp_r      <= '0;
         wr_count_r  <= '0;
         err_count_r <= '0;
      end else begin
         state_r     <= state_n;
         resp_r      <= resp_n;
         wr_count_r  <= wr_count_r + 16'(is_write);
         // error counter saturates rather than wrapping
         err_count_r <= err_count_r + 16'(is_bad & ~&err_count_r);
      end
   end
endmodule
